// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: state encoding,
// parity selectors, sample-point offsets and the majority voter.
package uart_rx_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Sample points sit at prescale/2 - LEAD, prescale/2, prescale/2 + LAG
    localparam int unsigned SAMPLE_LEAD = 1;
    localparam int unsigned SAMPLE_LAG  = 1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three-point capture around mid-bit and a
// registered majority vote of the three samples.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  active_i,
    input  logic                  rx_s_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  sampled_bit_o,
    output logic                  bit_done_c_o
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [1:0]            samples_q, samples_d;
    logic                  sampled_bit_q, sampled_bit_d;

    logic [PRESCALE_W-1:0] half_pt;
    logic [PRESCALE_W-1:0] pre_pt;
    logic [PRESCALE_W-1:0] post_pt;
    logic [PRESCALE_W-1:0] last_pt;

    assign half_pt = prescale_i >> 1;
    assign pre_pt  = half_pt - PRESCALE_W'(SAMPLE_LEAD);
    assign post_pt = half_pt + PRESCALE_W'(SAMPLE_LAG);
    assign last_pt = prescale_i - PRESCALE_W'(1);

    assign bit_done_c_o  = active_i && (edge_cnt_q == last_pt);
    assign sampled_bit_o = sampled_bit_q;

    always_comb begin
        edge_cnt_d    = '0;
        samples_d     = samples_q;
        sampled_bit_d = sampled_bit_q;
        if (active_i) begin
            edge_cnt_d = (edge_cnt_q == last_pt) ? '0 : edge_cnt_q + PRESCALE_W'(1);
            if (edge_cnt_q == pre_pt) begin
                samples_d[0] = rx_s_i;
            end
            if (edge_cnt_q == half_pt) begin
                samples_d[1] = rx_s_i;
            end
            // Third sample is taken live so the vote is ready one cycle later
            if (edge_cnt_q == post_pt) begin
                sampled_bit_d = majority3(samples_q[0], samples_q[1], rx_s_i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q    <= '0;
            samples_q     <= 2'b11;
            sampled_bit_q <= 1'b1;
        end else begin
            edge_cnt_q    <= edge_cnt_d;
            samples_q     <= samples_d;
            sampled_bit_q <= sampled_bit_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: line synchroniser, frame FSM, LSB-first deserialiser,
// parity/stop checking and registered result pulses.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    logic [1:0]            sync_q;
    logic                  rx_s;
    state_e                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_flag_q, par_flag_d;
    logic                  stop_flag_q, stop_flag_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;
    logic                  busy_q, busy_d;

    logic                  sampled_bit;
    logic                  bit_done;
    logic                  stop_fail;

    assign rx_s = sync_q[1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .active_i      (state_q != ST_IDLE),
        .rx_s_i        (rx_s),
        .prescale_i    (prescale_q),
        .sampled_bit_o (sampled_bit),
        .bit_done_c_o  (bit_done)
    );

    assign stop_fail = stop_flag_q | ~sampled_bit;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        par_flag_d     = par_flag_q;
        stop_flag_d    = stop_flag_q;
        prescale_d     = prescale_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                par_flag_d  = 1'b0;
                stop_flag_d = 1'b0;
                bit_cnt_d   = '0;
                if (!rx_s) begin
                    state_d    = ST_START;
                    prescale_d = prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = sampled_bit ? ST_IDLE : ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    if (sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD))) begin
                        par_flag_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    // Last stop bit closes the frame and publishes the verdict
                    if (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1)) begin
                        state_d        = ST_IDLE;
                        bit_cnt_d      = '0;
                        parity_error_d = par_flag_q;
                        stop_error_d   = stop_fail;
                        if (!par_flag_q && !stop_fail) begin
                            data_valid_d = 1'b1;
                            p_data_d     = shift_q;
                        end
                    end else begin
                        stop_flag_d = stop_fail;
                        bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            par_flag_q     <= 1'b0;
            stop_flag_q    <= 1'b0;
            prescale_q     <= PRESCALE_W'(8);
            par_en_q       <= 1'b0;
            par_typ_q      <= PAR_EVEN;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            par_flag_q     <= par_flag_d;
            stop_flag_q    <= stop_flag_d;
            prescale_q     <= prescale_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
            busy_q         <= busy_d;
        end
    end

    assign P_DATA       = p_data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected results,
// per-instance monitors pop and compare on every output pulse.
module tb_uart_rx_core;
    import uart_rx_pkg::*;

    typedef struct {
        logic [7:0] pdata;
        logic       dv;
        logic       pe;
        logic       se;
        longint     at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx1, rx2;
    logic [5:0] presc;
    logic       par_en, par_typ;

    logic [7:0] pd1, pd2;
    logic       dv1, pe1, se1, bz1;
    logic       dv2, pe2, se2, bz2;

    longint cyc = 0;
    int     total = 0;
    int     passed = 0;
    exp_t   q1[$];
    exp_t   q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_core #(.DATA_WIDTH(8), .STOP_BITS(1), .PRESCALE_W(6)) dut1 (
        .CLK(clk), .RST(rst_n), .RX_IN(rx1), .prescale(presc),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .P_DATA(pd1),
        .data_valid(dv1), .parity_error(pe1), .stop_error(se1), .busy(bz1)
    );

    uart_rx_core #(.DATA_WIDTH(8), .STOP_BITS(2), .PRESCALE_W(6)) dut2 (
        .CLK(clk), .RST(rst_n), .RX_IN(rx2), .prescale(presc),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .P_DATA(pd2),
        .data_valid(dv2), .parity_error(pe2), .stop_error(se2), .busy(bz2)
    );

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic v, input logic p,
                                input logic s, input longint at);
        exp_t e;
        e.pdata = d; e.dv = v; e.pe = p; e.se = s; e.at = at;
        return e;
    endfunction

    task automatic check_pulse(input string tag, input exp_t e, input logic [7:0] pd,
                               input logic dv, input logic pe, input logic se);
        check({tag, " data_valid"}, longint'(dv), longint'(e.dv));
        check({tag, " parity_error"}, longint'(pe), longint'(e.pe));
        check({tag, " stop_error"}, longint'(se), longint'(e.se));
        check({tag, " P_DATA"}, longint'(pd), longint'(e.pdata));
        if (e.at >= 0) check({tag, " pulse cycle"}, cyc, e.at);
    endtask

    // Monitors: every pulse cycle must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && (dv1 || pe1 || se1)) begin
            if (q1.size() == 0) check("dut1 unexpected pulse", 1, 0);
            else check_pulse("dut1", q1.pop_front(), pd1, dv1, pe1, se1);
        end
    end

    always @(negedge clk) begin
        if (rst_n && (dv2 || pe2 || se2)) begin
            if (q2.size() == 0) check("dut2 unexpected pulse", 1, 0);
            else check_pulse("dut2", q2.pop_front(), pd2, dv2, pe2, se2);
        end
    end

    task automatic set_line(input int inst, input logic b);
        if (inst == 1) rx1 = b;
        else rx2 = b;
    endtask

    task automatic hold_bit(input int inst, input logic b, input int p);
        set_line(inst, b);
        repeat (p) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge that ends the last stop bit
    task automatic send_frame(input int inst, input logic [7:0] data, input int p,
                              input logic pen, input logic pbit, input int nstop,
                              input logic [1:0] stops);
        presc  = 6'(p);
        par_en = pen;
        hold_bit(inst, 1'b0, p);
        for (int i = 0; i < 8; i++) hold_bit(inst, data[i], p);
        if (pen) hold_bit(inst, pbit, p);
        for (int i = 0; i < nstop; i++) hold_bit(inst, stops[i], p);
        set_line(inst, 1'b1);
    endtask

    task automatic wait_drain(input int inst, input int budget);
        int left;
        for (int i = 0; i < budget; i++) begin
            left = (inst == 1) ? q1.size() : q2.size();
            if (left == 0) break;
            @(negedge clk);
        end
        left = (inst == 1) ? q1.size() : q2.size();
        check($sformatf("dut%0d expected pulses arrived", inst), longint'(left), 0);
        if (inst == 1) q1.delete();
        else q2.delete();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        rx1     = 1'b1;
        rx2     = 1'b1;
        presc   = 6'd8;
        par_en  = 1'b0;
        par_typ = PAR_EVEN;
        repeat (3) @(negedge clk);
        check("reset P_DATA", longint'(pd1), 0);
        check("reset data_valid", longint'(dv1), 0);
        check("reset parity_error", longint'(pe1), 0);
        check("reset stop_error", longint'(se1), 0);
        check("reset busy", longint'(bz1), 0);
        check("reset dut2 busy", longint'(bz2), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean 0xA5 at prescale 8: pulse 3 + 10*8 cycles after the falling edge
        q1.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0, cyc + 83));
        send_frame(1, 8'hA5, 8, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(1, 200);

        // 0x3C has even weight, so even parity needs 0; sending 1 is an error
        par_typ = PAR_EVEN;
        q1.push_back(mk(8'hA5, 1'b0, 1'b1, 1'b0, cyc + 3 + 11 * 16));
        send_frame(1, 8'h3C, 16, 1'b1, 1'b1, 1, 2'b11);
        wait_drain(1, 400);

        // Three-cycle glitch: START entered, abandoned after one bit, no pulses
        presc = 6'd16;
        par_en = 1'b0;
        hold_bit(1, 1'b0, 3);
        hold_bit(1, 1'b1, 4);
        check("glitch busy during start", longint'(bz1), 1);
        repeat (30) @(negedge clk);
        check("glitch busy cleared", longint'(bz1), 0);
        check("glitch P_DATA held", longint'(pd1), 8'hA5);

        // Two stop bits: good 0x96, then 0x33 with second stop bit low
        q2.push_back(mk(8'h96, 1'b1, 1'b0, 1'b0, cyc + 3 + 11 * 8));
        send_frame(2, 8'h96, 8, 1'b0, 1'b0, 2, 2'b11);
        wait_drain(2, 200);
        q2.push_back(mk(8'h96, 1'b0, 1'b0, 1'b1, -1));
        send_frame(2, 8'h33, 8, 1'b0, 1'b0, 2, 2'b01);
        wait_drain(2, 200);

        // Back-to-back at prescale 32; second start is caught one cycle late
        q1.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, cyc + 3 + 320));
        q1.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b0, cyc + 320 + 4 + 320));
        send_frame(1, 8'h00, 32, 1'b0, 1'b0, 1, 2'b11);
        send_frame(1, 8'hFF, 32, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(1, 800);

        // Reset during DATA discards the frame, then a clean 0x5A
        presc = 6'd8;
        hold_bit(1, 1'b0, 24);
        check("pre-reset busy", longint'(bz1), 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-frame reset busy", longint'(bz1), 0);
        check("mid-frame reset P_DATA", longint'(pd1), 0);
        set_line(1, 1'b1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        q1.push_back(mk(8'h5A, 1'b1, 1'b0, 1'b0, cyc + 83));
        send_frame(1, 8'h5A, 8, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(1, 200);

        repeat (20) @(negedge clk);
        check("dut1 idle at end", longint'(bz1), 0);
        check("dut2 idle at end", longint'(bz2), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
